// File: rtl/frag_shade_reorder.sv
// Texture-fetch reorder buffer with per-channel modulate/bias shading; fragments retire in allocation order.
// Optional alpha test enabled by defining FRAG_ALPHA_TEST_EN.
module frag_shade_reorder #(
  parameter int unsigned TAG_BITS = 5,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CH_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_tex_addr,
  input  logic [NCH*CH_W-1:0]     in_mod,
  input  logic [NCH*CH_W-1:0]     in_bias,
  output logic                    tmu_req_valid,
  input  logic                    tmu_req_ready,
  output logic [ADDR_W-1:0]       tmu_req_addr,
  output logic [TAG_BITS-1:0]     tmu_req_tag,
  input  logic                    tmu_rsp_valid,
  input  logic [TAG_BITS-1:0]     tmu_rsp_tag,
  input  logic [NCH*CH_W-1:0]     tmu_rsp_color,
  input  logic [CH_W-1:0]         alpha_ref,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*CH_W-1:0]     out_color,
  output logic                    out_kill,
  output logic [TAG_BITS:0]       occupancy,
  output logic                    err
);

  localparam int unsigned DEPTH = 1 << TAG_BITS;
  localparam int unsigned CW    = NCH * CH_W;
  localparam logic [TAG_BITS:0] FULL = (TAG_BITS + 1)'(DEPTH);

  logic [TAG_BITS-1:0] head_q, head_d;
  logic [TAG_BITS-1:0] tail_q, tail_d;
  logic [TAG_BITS:0]   occ_q, occ_d;
  logic [DEPTH-1:0]    done_q, done_d;
  logic                err_q, err_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [TAG_BITS-1:0] req_tag_q, req_tag_d;
  logic                out_valid_q, out_valid_d;
  logic [CW-1:0]       out_color_q, out_color_d;
  logic                out_kill_q, out_kill_d;

  logic [CW-1:0] mod_mem  [DEPTH];
  logic [CW-1:0] bias_mem [DEPTH];
  logic [CW-1:0] tex_mem  [DEPTH];

  logic                accept;
  logic                retire;
  logic                rsp_ok;
  logic [TAG_BITS-1:0] rsp_off;
  logic [CW-1:0]       shaded;
  logic                shaded_kill;
  logic [2*CH_W-1:0]   prod;
  logic [CH_W:0]       sum;

  assign in_ready = (occ_q < FULL) && (!req_valid_q || tmu_req_ready);
  assign accept   = in_valid && in_ready;

  // A tag is live when its distance from head (mod DEPTH) is below the occupancy.
  assign rsp_off = tmu_rsp_tag - head_q;
  assign rsp_ok  = tmu_rsp_valid && ({1'b0, rsp_off} < occ_q) && !done_q[tmu_rsp_tag];

  assign retire  = (occ_q != '0) && done_q[head_q] && (!out_valid_q || out_ready);

  always_comb begin
    shaded = '0;
    prod   = '0;
    sum    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      prod = (2*CH_W)'(tex_mem[head_q][c*CH_W +: CH_W]) *
             (2*CH_W)'(mod_mem[head_q][c*CH_W +: CH_W]);
      sum  = (CH_W+1)'(prod[2*CH_W-1:CH_W]) + (CH_W+1)'(bias_mem[head_q][c*CH_W +: CH_W]);
      shaded[c*CH_W +: CH_W] = sum[CH_W] ? '1 : sum[CH_W-1:0];
    end
  end

`ifdef FRAG_ALPHA_TEST_EN
  assign shaded_kill = shaded[(NCH-1)*CH_W +: CH_W] < alpha_ref;
`else
  logic unused_alpha;
  assign unused_alpha = ^alpha_ref;
  assign shaded_kill  = 1'b0;
`endif

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    done_d      = done_q;
    err_d       = err_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_tag_d   = req_tag_q;
    out_valid_d = out_valid_q;
    out_color_d = out_color_q;
    out_kill_d  = out_kill_q;

    if (rsp_ok) begin
      done_d[tmu_rsp_tag] = 1'b1;
    end else if (tmu_rsp_valid) begin
      err_d = 1'b1;
    end

    if (accept) begin
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + TAG_BITS'(1);
      req_valid_d    = 1'b1;
      req_addr_d     = in_tex_addr;
      req_tag_d      = tail_q;
    end else if (req_valid_q && tmu_req_ready) begin
      req_valid_d = 1'b0;
    end

    if (retire) begin
      head_d      = head_q + TAG_BITS'(1);
      out_valid_d = 1'b1;
      out_color_d = shaded;
      out_kill_d  = shaded_kill;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({accept, retire})
      2'b10:   occ_d = occ_q + (TAG_BITS+1)'(1);
      2'b01:   occ_d = occ_q - (TAG_BITS+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
      out_kill_q  <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_tag_q   <= req_tag_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
      out_kill_q  <= out_kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mod_mem[tail_q]  <= in_mod;
      bias_mem[tail_q] <= in_bias;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_ok) begin
      tex_mem[tmu_rsp_tag] <= tmu_rsp_color;
    end
  end

  assign tmu_req_valid = req_valid_q;
  assign tmu_req_addr  = req_addr_q;
  assign tmu_req_tag   = req_tag_q;
  assign out_valid     = out_valid_q;
  assign out_color     = out_color_q;
  assign out_kill      = out_kill_q;
  assign occupancy     = occ_q;
  assign err           = err_q;

endmodule

// File: tb/tb_frag_shade_reorder.sv
// Bench for frag_shade_reorder: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_frag_shade_reorder;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_tex_addr = '0;
  logic [31:0] in_mod = '0;
  logic [31:0] in_bias = '0;
  logic        tmu_req_valid;
  logic        tmu_req_ready = 1'b0;
  logic [31:0] tmu_req_addr;
  logic [4:0]  tmu_req_tag;
  logic        tmu_rsp_valid = 1'b0;
  logic [4:0]  tmu_rsp_tag = '0;
  logic [31:0] tmu_rsp_color = '0;
  logic [7:0]  alpha_ref = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_color;
  logic        out_kill;
  logic [5:0]  occupancy;
  logic        err;

  always #5 clk = ~clk;

  frag_shade_reorder #(.TAG_BITS(5), .ADDR_W(32), .NCH(4), .CH_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tex_addr(in_tex_addr),
    .in_mod(in_mod), .in_bias(in_bias),
    .tmu_req_valid(tmu_req_valid), .tmu_req_ready(tmu_req_ready),
    .tmu_req_addr(tmu_req_addr), .tmu_req_tag(tmu_req_tag),
    .tmu_rsp_valid(tmu_rsp_valid), .tmu_rsp_tag(tmu_rsp_tag), .tmu_rsp_color(tmu_rsp_color),
    .alpha_ref(alpha_ref),
    .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color), .out_kill(out_kill),
    .occupancy(occupancy), .err(err)
  );

  // Reference model: pending fragments in allocation order plus the visible output/request registers.
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] mod;
    logic [31:0] bias;
    logic [31:0] tex;
    logic        done;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  m_next_tag = '0;
  logic        m_err = 1'b0, m_ov = 1'b0, m_ok = 1'b0, m_rv = 1'b0;
  logic [31:0] m_oc = '0, m_ra = '0;
  logic [4:0]  m_rt = '0;
  bit          chk_en = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] seen[$];

  function automatic logic [31:0] shade(input logic [31:0] t, input logic [31:0] m,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      s = ((32'(t[c*8 +: 8]) * 32'(m[c*8 +: 8])) >> 8) + 32'(b[c*8 +: 8]);
      r[c*8 +: 8] = (s > 32'd255) ? 8'hFF : s[7:0];
    end
    return r;
  endfunction

  function automatic logic kill_of(input logic [31:0] c);
`ifdef FRAG_ALPHA_TEST_EN
    return c[31:24] < alpha_ref;
`else
    return c[31:24] != c[31:24];
`endif
  endfunction

  function automatic logic m_in_ready();
    return (q.size() < DEPTH) && (!m_rv || tmu_req_ready);
  endfunction

  function automatic int pick_pending();
    int cand[$];
    for (int i = 0; i < q.size(); i++) if (!q[i].done) cand.push_back(i);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clk) begin : model
    int   idx;
    logic acc, ret;
    ent_t e;
    if (rst) begin
      q.delete();
      m_next_tag = '0; m_err = 1'b0; m_ov = 1'b0; m_oc = '0; m_ok = 1'b0;
      m_rv = 1'b0; m_ra = '0; m_rt = '0;
      chk_en = 1'b1;
    end else begin
      acc = in_valid && m_in_ready();
      ret = (q.size() != 0) && q[0].done && (!m_ov || out_ready);
      if (tmu_rsp_valid) begin
        idx = -1;
        for (int i = 0; i < q.size(); i++) if (q[i].tag == tmu_rsp_tag) idx = i;
        if (idx >= 0 && !q[idx].done) begin
          e = q[idx]; e.tex = tmu_rsp_color; e.done = 1'b1; q[idx] = e;
        end else begin
          m_err = 1'b1;
        end
      end
      if (ret) begin
        m_oc = shade(q[0].tex, q[0].mod, q[0].bias);
        m_ok = kill_of(m_oc);
        m_ov = 1'b1;
        void'(q.pop_front());
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        e.tag = m_next_tag; e.mod = in_mod; e.bias = in_bias; e.tex = '0; e.done = 1'b0;
        q.push_back(e);
        m_rv = 1'b1; m_ra = in_tex_addr; m_rt = m_next_tag;
        m_next_tag = m_next_tag + 5'd1;
      end else if (m_rv && tmu_req_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  64'(in_ready),      64'(m_in_ready()));
      check("occupancy", 64'(occupancy),     64'(q.size()));
      check("err",       64'(err),           64'(m_err));
      check("out_valid", 64'(out_valid),     64'(m_ov));
      check("out_color", 64'(out_color),     64'(m_oc));
      check("out_kill",  64'(out_kill),      64'(m_ok));
      check("req_valid", 64'(tmu_req_valid), 64'(m_rv));
      check("req_addr",  64'(tmu_req_addr),  64'(m_ra));
      check("req_tag",   64'(tmu_req_tag),   64'(m_rt));
      if (out_valid && out_ready) seen.push_back(out_color);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] m, input logic [31:0] b);
    int unsigned n;
    in_valid = 1'b1; in_tex_addr = a; in_mod = m; in_bias = b;
    n = 0;
    while (!m_in_ready() && n < 200) begin tick(); n++; end
    if (n >= 200) check("push_timeout", 64'(m_in_ready()), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic respond(input logic [4:0] t, input logic [31:0] c);
    tmu_rsp_valid = 1'b1; tmu_rsp_tag = t; tmu_rsp_color = c;
    tick();
    tmu_rsp_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int unsigned n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check(name, 64'(out_valid), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          base, p, cyc, idx;
    logic        acc_now;
    logic [7:0]  pk;

    tick(); tick();
    rst = 1'b0;
    tmu_req_ready = 1'b1;
    out_ready = 1'b1;
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));

    // Single fragment, 1-edge latency from response to out_valid
    push(32'h100, 32'h80808080, 32'h0);
    check("t1_req_addr", 64'(tmu_req_addr), 64'h100);
    check("t1_req_tag", 64'(tmu_req_tag), 64'(0));
    check("t1_occ", 64'(occupancy), 64'(1));
    tick();
    respond(5'd0, 32'hC8C8C8C8);
    check("t1_no_bypass", 64'(out_valid), 64'(0));
    tick();
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_color", 64'(out_color), 64'h64646464);
    tick();

    // Saturation
    push(32'h200, 32'hFFFFFFFF, 32'h10101010);
    tick();
    respond(5'd1, 32'hFFFFFFFF);
    wait_out("t2_valid");
    check("t2_color", 64'(out_color), 64'hFFFFFFFF);
    tick();

    // Out-of-order responses retire in allocation order
    do_reset();
    push(32'h10, 32'h0, 32'h11111111);
    push(32'h20, 32'h0, 32'h22222222);
    push(32'h30, 32'h0, 32'h33333333);
    check("t3_occ3", 64'(occupancy), 64'(3));
    base = seen.size();
    respond(5'd2, 32'hAAAAAAAA);
    respond(5'd0, 32'hBBBBBBBB);
    respond(5'd1, 32'hCCCCCCCC);
    for (int i = 0; i < 20 && seen.size() < base + 3; i++) tick();
    tick();
    check("t3_first",  64'(seen[base]),     64'h11111111);
    check("t3_second", 64'(seen[base + 1]), 64'h22222222);
    check("t3_third",  64'(seen[base + 2]), 64'h33333333);
    check("t3_occ0", 64'(occupancy), 64'(0));

    // Stray response while empty, then reset with pending entries
    respond(5'd7, 32'hDEADBEEF);
    check("t4_err", 64'(err), 64'(1));
    check("t4_no_out", 64'(out_valid), 64'(0));
    tick();
    check("t4_err_sticky", 64'(err), 64'(1));
    for (int k = 0; k < 5; k++) push(32'h400 + 32'(k), $urandom, $urandom);
    check("t4_occ5", 64'(occupancy), 64'(5));
    do_reset();
    check("t4_rst_occ", 64'(occupancy), 64'(0));
    check("t4_rst_err", 64'(err), 64'(0));
    check("t4_rst_color", 64'(out_color), 64'(0));
    check("t4_rst_req_valid", 64'(tmu_req_valid), 64'(0));
    check("t4_rst_req_addr", 64'(tmu_req_addr), 64'(0));
    respond(5'd2, 32'h12345678);
    check("t4_late_rsp_err", 64'(err), 64'(1));
    do_reset();

    // Fill to capacity, then drain with tag wrap and 50% out_ready
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      pk = 8'(k);
      push(32'(k), 32'h0, {4{pk}});
    end
    in_valid = 1'b1;
    tick();
    check("t5_full_occ", 64'(occupancy), 64'(32));
    check("t5_full_in_ready", 64'(in_ready), 64'(0));
    base = seen.size();
    p = 32;
    cyc = 0;
    while (seen.size() < base + 40 && cyc < 3000) begin
      pk = 8'(p);
      in_valid = (p < 40);
      in_mod = '0; in_bias = {4{pk}}; in_tex_addr = 32'(p);
      acc_now = in_valid && m_in_ready();
      idx = pick_pending();
      if (idx >= 0) begin
        tmu_rsp_valid = 1'b1; tmu_rsp_tag = q[idx].tag; tmu_rsp_color = $urandom;
      end else begin
        tmu_rsp_valid = 1'b0;
      end
      out_ready = cyc[0];
      tick();
      if (acc_now) begin
        p++;
        if (p == 33) check("t5_wrap_tag", 64'(tmu_req_tag), 64'(0));
      end
      cyc++;
    end
    in_valid = 1'b0; tmu_rsp_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("t5_all_retired", 64'(seen.size()), 64'(base + 40));
    for (int k = 0; k < 40; k++) begin
      pk = 8'(k);
      check("t5_order", 64'(seen[base + k]), 64'({4{pk}}));
    end
    check("t5_occ0", 64'(occupancy), 64'(0));

    // Alpha test threshold
    alpha_ref = 8'h80;
    push(32'h300, 32'h0, 32'h7F000000);
    tick();
    respond(q[0].tag, 32'h0);
    wait_out("t6_valid_a");
`ifdef FRAG_ALPHA_TEST_EN
    check("t6_kill_below", 64'(out_kill), 64'(1));
`else
    check("t6_kill_disabled", 64'(out_kill), 64'(0));
`endif
    tick();
    push(32'h304, 32'h0, 32'h80000000);
    tick();
    respond(q[0].tag, 32'h0);
    wait_out("t6_valid_b");
    check("t6_kill_equal", 64'(out_kill), 64'(0));
    tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(9) < 6);
      in_tex_addr = $urandom;
      in_mod      = $urandom;
      in_bias     = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h3F3F3F3F);
      tmu_req_ready = ($urandom_range(9) < 7);
      out_ready   = ($urandom_range(1) == 1);
      alpha_ref   = 8'($urandom);
      idx = pick_pending();
      if (idx >= 0 && $urandom_range(9) < 5) begin
        tmu_rsp_valid = 1'b1; tmu_rsp_tag = q[idx].tag; tmu_rsp_color = $urandom;
      end else begin
        tmu_rsp_valid = 1'b0;
      end
      rst = (c == 1500);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; tmu_rsp_valid = 1'b0;
    tick();
    check("rand_no_err", 64'(err), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/frag_shade_reorder.md
FRAG_SHADE_REORDER -- requirements
Module: frag_shade_reorder

Interface
REQ-001 Parameter TAG_BITS, 5, tag width; DEPTH = 2^TAG_BITS pending entries.
REQ-002 Parameter ADDR_W, 32, texel address width.
REQ-003 Parameter NCH, 4, colour channels; channel NCH-1 is alpha.
REQ-004 Parameter CH_W, 8, bits per channel; CW = NCH*CH_W.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid / in_ready  in / out  1 / 1  fragment handshake.
REQ-008 in_tex_addr  in  ADDR_W  texel address.
REQ-009 in_mod  in  CW  per-channel modulate factor, unsigned, 1.0 = 2^CH_W.
REQ-010 in_bias  in  CW  per-channel additive bias, unsigned.
REQ-011 tmu_req_valid / tmu_req_ready  out / in  1 / 1  TMU request handshake.
REQ-012 tmu_req_addr / tmu_req_tag  out / out  ADDR_W / TAG_BITS  request payload.
REQ-013 tmu_rsp_valid / tmu_rsp_tag / tmu_rsp_color  in / in / in  1 / TAG_BITS / CW  TMU response; any order; always accepted.
REQ-014 alpha_ref  in  CH_W  alpha-test threshold.
REQ-015 out_valid / out_ready  out / in  1 / 1  shaded output handshake.
REQ-016 out_color / out_kill  out / out  CW / 1  shaded colour; discard flag.
REQ-017 occupancy  out  TAG_BITS+1  allocated entries, 0..DEPTH.
REQ-018 err  out  1  sticky protocol error.

Function
REQ-019 in_ready = (occupancy < DEPTH) && (!tmu_req_valid || tmu_req_ready), combinational.
REQ-020 Accept (in_valid && in_ready) stores in_mod/in_bias at tail, clears done[tail], loads request register (valid=1, addr, tag=tail), tail wraps modulo DEPTH.
REQ-021 Request payload held stable while tmu_req_valid && !tmu_req_ready; valid drops after handshake unless a new accept reloads it the same edge.
REQ-022 Response sampled at edge N with tag allocated and not done: colour stored, done[tag] set.
REQ-023 Response to an unallocated or already-done tag: ignored, err set to 1 until reset.
REQ-024 Retire in strict allocation order: head retires at an edge when done[head] && (!out_valid || out_ready); head wraps modulo DEPTH.
REQ-025 Response at edge N for the head entry with free output: out_valid rises at edge N+1; no same-edge bypass.
REQ-026 Per channel c: p = tex_c*mod_c (2*CH_W bits); s = (p >> CH_W) + bias_c (CH_W+1 bits); out_c = min(s, 2^CH_W-1).
REQ-027 out_valid/out_color/out_kill held stable until out_ready; out_valid drops after handshake unless a retire reloads it.
REQ-028 Allocate and retire at the same edge: occupancy unchanged, both complete.
REQ-029 occupancy == DEPTH: in_ready = 0; responses and retires still proceed.
REQ-030 occupancy == 0: no retire; out_valid falls after the last handshake.

Reset
REQ-031 rst at any edge: head, tail, occupancy, done bits, err, tmu_req_valid, out_valid, out_kill, out_color, tmu_req_addr and tmu_req_tag all 0. In-flight entries are discarded.
REQ-032 Responses arriving after reset target unallocated tags and fall under REQ-023.
REQ-033 Entry storage needs no reset.

Configuration
REQ-034 Macro FRAG_ALPHA_TEST_EN defined: out_kill = 1 when shaded alpha (channel NCH-1) < alpha_ref. The fragment still retires in order with out_valid asserted.
REQ-035 Macro FRAG_ALPHA_TEST_EN undefined: alpha_ref ignored, out_kill constant 0.

Verification
REQ-036 Single fragment: addr 0x100, mod all 0x80, bias 0, tmu_req_ready=1; response tag 0 colour 0xC8C8C8C8 -> out_color 0x64646464, out_valid rises 1 edge after response.
REQ-037 Saturation: tex 0xFF, mod 0xFF, bias 0x10 all channels -> out_color 0xFFFFFFFF.
REQ-038 Out-of-order: allocate tags 0,1,2; respond 2,0,1 -> outputs in order 0,1,2; occupancy 3->0.
REQ-039 Full/wrap: 40 fragments with responses withheld -> in_ready=0 at occupancy 32. Then respond to all -> tags wrap 31->0, all 40 retire in order, out_ready toggled 50%.
REQ-040 Error/reset: response tag 7 while empty -> err=1, no output. Reset with 5 pending -> occupancy 0, err 0, all outputs 0.
REQ-041 With FRAG_ALPHA_TEST_EN: alpha_ref 0x80, shaded alpha 0x7F -> out_kill=1; shaded alpha 0x80 -> out_kill=0.
